// File: rtl/vending_machine_gen.sv
// Vending machine controller: accumulates nickel/dime/quarter credit,
// offers one item through a valid/ready handshake once the price is
// reached, then returns any excess (or a full refund on cancel) as a
// single-cycle change strobe. Every output comes straight from a register.
module vending_machine_gen #(
    parameter int PRICE    = 4,
    parameter int CREDIT_W = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                nickel_i,
    input  logic                dime_i,
    input  logic                quarter_i,
    input  logic                cancel_i,
    input  logic                soda_ready_i,
    output logic                soda_valid_o,
    output logic                change_valid_o,
    output logic [CREDIT_W-1:0] change_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                coin_reject_o,
    output logic                coin_err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_e;

    localparam logic [CREDIT_W-1:0] PriceC = CREDIT_W'(PRICE);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                sodaValid_q, sodaValid_d;
    logic                changeValid_q, changeValid_d;
    logic                coinReject_q, coinReject_d;
    logic                coinErr_q, coinErr_d;

    logic [1:0]          coinCount;
    logic                coinAny;
    logic                coinMulti;
    logic [CREDIT_W-1:0] coinValue;
    logic [CREDIT_W-1:0] sumCredit;
    logic [CREDIT_W-1:0] excess;

    // Decode the coin strobes: how many are high and what a single coin is worth.
    always_comb begin
        coinCount = {1'b0, nickel_i} + {1'b0, dime_i} + {1'b0, quarter_i};
        coinAny   = (coinCount != 2'd0);
        coinMulti = (coinCount > 2'd1);
        coinValue = '0;
        if (nickel_i) begin
            coinValue = CREDIT_W'(1);
        end else if (dime_i) begin
            coinValue = CREDIT_W'(2);
        end else if (quarter_i) begin
            coinValue = CREDIT_W'(5);
        end
        sumCredit = credit_q + coinValue;
        excess    = credit_q - PriceC;
    end

    // Next-state and next-output logic; a multi-hot coin is always flagged and returned.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        change_d      = '0;
        changeValid_d = 1'b0;
        sodaValid_d   = 1'b0;
        coinErr_d     = coinMulti;
        coinReject_d  = coinMulti;

        unique case (state_q)
            IDLE, COLLECT: begin
                if ((state_q == COLLECT) && cancel_i) begin
                    state_d       = CHANGE;
                    changeValid_d = 1'b1;
                    change_d      = credit_q;
                    coinReject_d  = coinAny;
                end else if (coinAny && !coinMulti) begin
                    credit_d = sumCredit;
                    if (sumCredit >= PriceC) begin
                        state_d     = VEND;
                        sodaValid_d = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            VEND: begin
                sodaValid_d  = 1'b1;
                coinReject_d = coinAny;
                if (sodaValid_q && soda_ready_i) begin
                    sodaValid_d = 1'b0;
                    if (excess != '0) begin
                        state_d       = CHANGE;
                        changeValid_d = 1'b1;
                        change_d      = excess;
                    end else begin
                        state_d  = IDLE;
                        credit_d = '0;
                    end
                end
            end
            CHANGE: begin
                coinReject_d = coinAny;
                state_d      = IDLE;
                credit_d     = '0;
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            change_q      <= '0;
            sodaValid_q   <= 1'b0;
            changeValid_q <= 1'b0;
            coinReject_q  <= 1'b0;
            coinErr_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            change_q      <= change_d;
            sodaValid_q   <= sodaValid_d;
            changeValid_q <= changeValid_d;
            coinReject_q  <= coinReject_d;
            coinErr_q     <= coinErr_d;
        end
    end

    assign soda_valid_o   = sodaValid_q;
    assign change_valid_o = changeValid_q;
    assign change_o       = change_q;
    assign credit_o       = credit_q;
    assign coin_reject_o  = coinReject_q;
    assign coin_err_o     = coinErr_q;

endmodule

// File: tb/tb_vending_machine_gen.sv
// Self-checking bench for vending_machine_gen: a behavioural model predicts
// the registered outputs for every driven cycle, pushes them to a scoreboard
// queue, and they are popped and compared just after the clock edge.
module tb_vending_machine_gen;

    localparam int PRICE    = 4;
    localparam int CREDIT_W = 5;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                nickel_i = 1'b0;
    logic                dime_i = 1'b0;
    logic                quarter_i = 1'b0;
    logic                cancel_i = 1'b0;
    logic                soda_ready_i = 1'b0;
    logic                soda_valid_o;
    logic                change_valid_o;
    logic [CREDIT_W-1:0] change_o;
    logic [CREDIT_W-1:0] credit_o;
    logic                coin_reject_o;
    logic                coin_err_o;

    typedef struct {
        int sodaValid;
        int changeValid;
        int change;
        int credit;
        int coinReject;
        int coinErr;
    } expect_t;

    expect_t sbQueue[$];

    int checks = 0;
    int errors = 0;

    // Model state: 0 idle, 1 collect, 2 vend, 3 change.
    int mState  = 0;
    int mCredit = 0;

    vending_machine_gen #(
        .PRICE   (PRICE),
        .CREDIT_W(CREDIT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .nickel_i      (nickel_i),
        .dime_i        (dime_i),
        .quarter_i     (quarter_i),
        .cancel_i      (cancel_i),
        .soda_ready_i  (soda_ready_i),
        .soda_valid_o  (soda_valid_o),
        .change_valid_o(change_valid_o),
        .change_o      (change_o),
        .credit_o      (credit_o),
        .coin_reject_o (coin_reject_o),
        .coin_err_o    (coin_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance the reference model by one clock and return the outputs it predicts.
    task automatic modelStep(input bit rst, input bit n, input bit d, input bit q,
                             input bit c, input bit r, output expect_t e);
        int cnt;
        int val;
        int diff;
        cnt = int'(n) + int'(d) + int'(q);
        val = n ? 1 : (d ? 2 : (q ? 5 : 0));
        e.changeValid = 0;
        e.change      = 0;
        e.coinReject  = 0;
        e.coinErr     = 0;
        if (!rst) begin
            mState  = 0;
            mCredit = 0;
        end else begin
            if (cnt > 1) begin
                e.coinErr    = 1;
                e.coinReject = 1;
            end
            case (mState)
                0, 1: begin
                    if (mState == 1 && c) begin
                        if (cnt >= 1) e.coinReject = 1;
                        e.changeValid = 1;
                        e.change      = mCredit;
                        mState        = 3;
                    end else if (cnt == 1) begin
                        mCredit = (mCredit + val) % (1 << CREDIT_W);
                        mState  = (mCredit >= PRICE) ? 2 : 1;
                    end
                end
                2: begin
                    if (cnt >= 1) e.coinReject = 1;
                    if (r) begin
                        diff = mCredit - PRICE;
                        if (diff > 0) begin
                            mState        = 3;
                            e.changeValid = 1;
                            e.change      = diff;
                        end else begin
                            mState  = 0;
                            mCredit = 0;
                        end
                    end
                end
                default: begin
                    if (cnt >= 1) e.coinReject = 1;
                    mState  = 0;
                    mCredit = 0;
                end
            endcase
        end
        e.sodaValid = (mState == 2) ? 1 : 0;
        e.credit    = mCredit;
    endtask

    // Drive one cycle of inputs, predict the result, and compare it after the edge.
    task automatic applyStimulus(input bit rst, input bit n, input bit d, input bit q,
                                 input bit c, input bit r);
        expect_t e;
        @(negedge clk_i);
        rst_ni       = rst;
        nickel_i     = n;
        dime_i       = d;
        quarter_i    = q;
        cancel_i     = c;
        soda_ready_i = r;
        modelStep(rst, n, d, q, c, r, e);
        sbQueue.push_back(e);
        @(posedge clk_i);
        #1;
        if (sbQueue.size() == 0) begin
            checkOutput("sb_empty", 0, 1);
        end else begin
            e = sbQueue.pop_front();
            checkOutput("soda_valid", int'(soda_valid_o), e.sodaValid);
            checkOutput("change_valid", int'(change_valid_o), e.changeValid);
            checkOutput("change", int'(change_o), e.change);
            checkOutput("credit", int'(credit_o), e.credit);
            checkOutput("coin_reject", int'(coin_reject_o), e.coinReject);
            checkOutput("coin_err", int'(coin_err_o), e.coinErr);
            if (!change_valid_o) checkOutput("change_zero", int'(change_o), 0);
        end
    endtask

    initial begin
        $display("[TB] starting vending_machine_gen bench");
        // Reset with coins held high: inputs must be ignored.
        applyStimulus(0, 1, 1, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst_credit", int'(credit_o), 0);

        // Quarter from idle, dispenser ready: vend then one nickel of change.
        applyStimulus(1, 0, 0, 1, 0, 1);
        checkOutput("q_credit", int'(credit_o), 5);
        checkOutput("q_soda", int'(soda_valid_o), 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("q_change", int'(change_o), 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("q_idle_credit", int'(credit_o), 0);

        // Two dimes: exact price, no change.
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("dd_credit1", int'(credit_o), 2);
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("dd_credit2", int'(credit_o), 4);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("dd_no_change", int'(change_valid_o), 0);

        // Nickel, dime, quarter: 1, 3, 8 then change of 4.
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("ndq_credit", int'(credit_o), 8);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("ndq_change", int'(change_o), 4);
        applyStimulus(1, 0, 0, 0, 0, 0);

        // Stalled dispenser for five cycles, quarter rejected meanwhile.
        applyStimulus(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, (i == 2), 0, 0);
            checkOutput("stall_soda", int'(soda_valid_o), 1);
            checkOutput("stall_credit", int'(credit_o), 5);
        end
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0);

        // Dime then cancel: refund 2.
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("cancel_refund", int'(change_o), 2);
        applyStimulus(1, 0, 0, 0, 0, 0);
        // Dime then cancel plus nickel: refund 2 and reject the nickel.
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 0);
        checkOutput("cancel_coin_reject", int'(coin_reject_o), 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        // Cancel in idle is ignored; nickel+dime together is an error.
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 1, 0, 0, 0);
        checkOutput("multi_err", int'(coin_err_o), 1);
        applyStimulus(1, 0, 0, 0, 0, 0);

        // Reset while vending with credit 5.
        applyStimulus(1, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("rst_vend_soda", int'(soda_valid_o), 0);
        applyStimulus(1, 0, 0, 0, 0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(99) >= 2,
                          $urandom_range(99) < 15,
                          $urandom_range(99) < 15,
                          $urandom_range(99) < 10,
                          $urandom_range(99) < 8,
                          $urandom_range(99) < 50);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
